// File: rtl/i2c_line_conditioner.sv
// i2c_line_conditioner
// Per-bus input conditioner between the SCL/SDA pad buffers and the
// pad-facing inputs of the I2C bus-sharing interconnect. Both lines are
// synchronised and glitch-filtered. START/STOP conditions and bus busy are
// derived from the filtered lines. An optional SCL stuck-low monitor raises
// a sticky flag for software.
//
// Optional feature macro: I2C_LINE_CONDITIONER_TIMEOUT_EN
//   defined   : stuck-low counter and sticky stuck_low flag are built
//   undefined : stuck_low is tied to 0; timeout_limit and stuck_clr are unused
//
// Parameters
//   SYNC_STAGES   synchroniser depth per line (>= 2)
//   FILTER_LEN    cycles a new synchronised level must hold (>= 1)
//   TIMEOUT_W     width of the stuck-low counter and timeout_limit
// Ports
//   clk, rst        single clock, asynchronous active-high reset
//   scl_pad_i       raw asynchronous SCL from the pad
//   sda_pad_i       raw asynchronous SDA from the pad
//   scl_i, sda_i    filtered lines towards the interconnect
//   start_det       one-cycle pulse on START / repeated START
//   stop_det        one-cycle pulse on STOP
//   bus_busy        high between START and STOP
//   timeout_limit   SCL-low cycles counted as stuck (0 disables)
//   stuck_low       sticky stuck-SCL flag
//   stuck_clr       single-cycle clear for stuck_low

module i2c_line_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned TIMEOUT_W   = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl_pad_i,
  input  logic                 sda_pad_i,
  output logic                 scl_i,
  output logic                 sda_i,
  output logic                 start_det,
  output logic                 stop_det,
  output logic                 bus_busy,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 stuck_low,
  input  logic                 stuck_clr
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  // Line index 0 = SCL, 1 = SDA
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic [1:0]             x_s;
  logic [1:0]             filt;

  // Synchroniser chains, idle-high after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pad_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pad_i};
    end
  end

  assign x_s = {sda_sync[SYNC_STAGES-1], scl_sync[SYNC_STAGES-1]};

  // Glitch filter: output follows only after FILTER_LEN consecutive differing samples
  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic          f_q;
    logic [CW-1:0] c_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        f_q <= 1'b1;
        c_q <= '0;
      end else if (x_s[g] == f_q) begin
        c_q <= '0;
      end else if (c_q == CW'(FILTER_LEN - 1)) begin
        f_q <= x_s[g];
        c_q <= '0;
      end else begin
        c_q <= c_q + CW'(1);
      end
    end

    assign filt[g] = f_q;
  end

  assign scl_i = filt[0];
  assign sda_i = filt[1];

  // Delayed copies reset low so a START needs the lines to be seen high first
  logic scl_d;
  logic sda_d;
  logic start_c;
  logic stop_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_d <= 1'b0;
      sda_d <= 1'b0;
    end else begin
      scl_d <= scl_i;
      sda_d <= sda_i;
    end
  end

  // SCL must be high both before and after, which rejects simultaneous edges
  always_comb begin
    start_c = 1'b0;
    stop_c  = 1'b0;
    if (scl_d && scl_i) begin
      start_c = sda_d && !sda_i;
      stop_c  = !sda_d && sda_i;
    end
  end

  // Registered event pulses and busy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      start_det <= start_c;
      stop_det  <= stop_c;
      if (start_c) begin
        bus_busy <= 1'b1;
      end else if (stop_c) begin
        bus_busy <= 1'b0;
      end
    end
  end

`ifdef I2C_LINE_CONDITIONER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt;
  logic                 limit_en;
  logic                 stuck_q;

  assign limit_en = (timeout_limit != '0);

  // SCL-low counter; holds (never wraps) when above a lowered limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (scl_i) begin
      tcnt <= '0;
    end else if (limit_en && (tcnt < timeout_limit)) begin
      tcnt <= tcnt + TIMEOUT_W'(1);
    end
  end

  // Sticky flag; clear wins, but re-sets next cycle if the count still matches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck_q <= 1'b0;
    end else if (stuck_clr) begin
      stuck_q <= 1'b0;
    end else if (limit_en && (tcnt == timeout_limit)) begin
      stuck_q <= 1'b1;
    end
  end

  assign stuck_low = stuck_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^{timeout_limit, stuck_clr};
  assign stuck_low      = 1'b0;
`endif

endmodule
